// File: rtl/vmem_arbiter.sv
// Two-requester (load/store) arbiter for the four data-memory banks, round-robin on ties.
// Optional grant watchdog is compiled in when VMEM_ARB_TIMEOUT_EN is defined.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 8
`endif
`ifndef DATAMEM_WIDTH
`define DATAMEM_WIDTH 32
`endif

module vmem_arbiter #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ld_req,
   input  logic                      ld_done,
   input  logic [`DATAMEM_BITS-1:0]  ld_addr0,
   input  logic [`DATAMEM_BITS-1:0]  ld_addr1,
   input  logic [`DATAMEM_BITS-1:0]  ld_addr2,
   input  logic [`DATAMEM_BITS-1:0]  ld_addr3,
   input  logic                      st_req,
   input  logic                      st_done,
   input  logic [`DATAMEM_BITS-1:0]  st_addr0,
   input  logic [`DATAMEM_BITS-1:0]  st_addr1,
   input  logic [`DATAMEM_BITS-1:0]  st_addr2,
   input  logic [`DATAMEM_BITS-1:0]  st_addr3,
   input  logic [`DATAMEM_WIDTH-1:0] st_data0,
   input  logic [`DATAMEM_WIDTH-1:0] st_data1,
   input  logic [`DATAMEM_WIDTH-1:0] st_data2,
   input  logic [`DATAMEM_WIDTH-1:0] st_data3,
   input  logic [3:0]                st_we,
   output logic [`DATAMEM_BITS-1:0]  mem_addr0,
   output logic [`DATAMEM_BITS-1:0]  mem_addr1,
   output logic [`DATAMEM_BITS-1:0]  mem_addr2,
   output logic [`DATAMEM_BITS-1:0]  mem_addr3,
   output logic [`DATAMEM_WIDTH-1:0] mem_wdata0,
   output logic [`DATAMEM_WIDTH-1:0] mem_wdata1,
   output logic [`DATAMEM_WIDTH-1:0] mem_wdata2,
   output logic [`DATAMEM_WIDTH-1:0] mem_wdata3,
   output logic [3:0]                mem_we,
   output logic                      ld_gnt,
   output logic                      st_gnt,
   output logic                      busy,
   output logic                      timeout_err
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_GRANT_LD = 2'd1;
   localparam logic [1:0] S_GRANT_ST = 2'd2;
   localparam logic [1:0] S_RELEASE  = 2'd3;

   localparam logic SRV_LD = 1'b0;
   localparam logic SRV_ST = 1'b1;

   logic [1:0] state_q, state_d;
   logic       last_served_q, last_served_d;
   logic       owner_q, owner_d;
   logic       ld_gnt_q, ld_gnt_d;
   logic       st_gnt_q, st_gnt_d;
   logic       busy_q, busy_d;
   logic       granted_s;
   logic       owner_req_s;
   logic       owner_done_s;
   logic       wd_expire_s;

   assign granted_s    = (state_q == S_GRANT_LD) || (state_q == S_GRANT_ST);
   assign owner_req_s  = (state_q == S_GRANT_ST) ? st_req  : ld_req;
   assign owner_done_s = (state_q == S_GRANT_ST) ? st_done : ld_done;

`ifdef VMEM_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CW-1:0] wd_cnt_q, wd_cnt_d;
   logic          timeout_err_q, timeout_err_d;

   assign wd_expire_s = (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));

   // Watchdog counts cycles spent in the current grant; it restarts on every new grant.
   always_comb begin
      wd_cnt_d      = {CW{1'b0}};
      timeout_err_d = timeout_err_q;
      if (granted_s && (state_d == state_q)) begin
         wd_cnt_d = wd_cnt_q + CW'(1'b1);
      end else begin
         wd_cnt_d = {CW{1'b0}};
      end
      if (granted_s && wd_expire_s && !owner_done_s && owner_req_s) begin
         timeout_err_d = 1'b1;
      end else begin
         timeout_err_d = timeout_err_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_q      <= {CW{1'b0}};
         timeout_err_q <= 1'b0;
      end else begin
         wd_cnt_q      <= wd_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign wd_expire_s = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Next-state logic: done beats a dropped request, which beats the watchdog.
   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      owner_d       = owner_q;
      case (state_q)
         S_IDLE: begin
            if (ld_req && st_req) begin
               if (last_served_q == SRV_ST) begin
                  state_d = S_GRANT_LD;
               end else begin
                  state_d = S_GRANT_ST;
               end
            end else if (ld_req) begin
               state_d = S_GRANT_LD;
            end else if (st_req) begin
               state_d = S_GRANT_ST;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GRANT_LD, S_GRANT_ST: begin
            owner_d = (state_q == S_GRANT_ST) ? SRV_ST : SRV_LD;
            if (owner_done_s || !owner_req_s || wd_expire_s) begin
               state_d = S_RELEASE;
            end else begin
               state_d = state_q;
            end
         end
         S_RELEASE: begin
            state_d       = S_IDLE;
            last_served_d = owner_q;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      ld_gnt_d = (state_d == S_GRANT_LD);
      st_gnt_d = (state_d == S_GRANT_ST);
      busy_d   = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         last_served_q <= SRV_ST;
         owner_q       <= SRV_LD;
         ld_gnt_q      <= 1'b0;
         st_gnt_q      <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         owner_q       <= owner_d;
         ld_gnt_q      <= ld_gnt_d;
         st_gnt_q      <= st_gnt_d;
         busy_q        <= busy_d;
      end
   end

   assign ld_gnt = ld_gnt_q;
   assign st_gnt = st_gnt_q;
   assign busy   = busy_q;

   // Bank mux: the owner drives the banks straight through; otherwise the bus is parked at zero.
   always_comb begin
      mem_addr0  = {`DATAMEM_BITS{1'b0}};
      mem_addr1  = {`DATAMEM_BITS{1'b0}};
      mem_addr2  = {`DATAMEM_BITS{1'b0}};
      mem_addr3  = {`DATAMEM_BITS{1'b0}};
      mem_wdata0 = {`DATAMEM_WIDTH{1'b0}};
      mem_wdata1 = {`DATAMEM_WIDTH{1'b0}};
      mem_wdata2 = {`DATAMEM_WIDTH{1'b0}};
      mem_wdata3 = {`DATAMEM_WIDTH{1'b0}};
      mem_we     = 4'b0000;
      case (state_q)
         S_GRANT_LD: begin
            mem_addr0 = ld_addr0;
            mem_addr1 = ld_addr1;
            mem_addr2 = ld_addr2;
            mem_addr3 = ld_addr3;
         end
         S_GRANT_ST: begin
            mem_addr0  = st_addr0;
            mem_addr1  = st_addr1;
            mem_addr2  = st_addr2;
            mem_addr3  = st_addr3;
            mem_wdata0 = st_data0;
            mem_wdata1 = st_data1;
            mem_wdata2 = st_data2;
            mem_wdata3 = st_data3;
            mem_we     = st_we;
         end
         default: begin
            mem_we = 4'b0000;
         end
      endcase
   end

endmodule

// File: tb/tb_vmem_arbiter.sv
// Randomised bench for vmem_arbiter: a transaction-level ownership model predicts every cycle's
// outputs into a queue, and an independent monitor compares them against the DUT.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 8
`endif
`ifndef DATAMEM_WIDTH
`define DATAMEM_WIDTH 32
`endif

module tb_vmem_arbiter;

   localparam int AW = `DATAMEM_BITS;
   localparam int DW = `DATAMEM_WIDTH;
`ifdef VMEM_ARB_TIMEOUT_EN
   localparam int  TO    = 8;
   localparam bit  WD_EN = 1'b1;
`else
   localparam int  TO    = 64;
   localparam bit  WD_EN = 1'b0;
`endif

   typedef struct packed {
      logic          ld_gnt;
      logic          st_gnt;
      logic          busy;
      logic          err;
      logic [3:0]    we;
      logic [4*AW-1:0] addr;
      logic [4*DW-1:0] wdata;
   } out_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ld_req = 1'b0, ld_done = 1'b0, st_req = 1'b0, st_done = 1'b0;
   logic [AW-1:0] ld_addr0 = '0, ld_addr1 = '0, ld_addr2 = '0, ld_addr3 = '0;
   logic [AW-1:0] st_addr0 = '0, st_addr1 = '0, st_addr2 = '0, st_addr3 = '0;
   logic [DW-1:0] st_data0 = '0, st_data1 = '0, st_data2 = '0, st_data3 = '0;
   logic [3:0]    st_we = 4'h0;
   logic [AW-1:0] mem_addr0, mem_addr1, mem_addr2, mem_addr3;
   logic [DW-1:0] mem_wdata0, mem_wdata1, mem_wdata2, mem_wdata3;
   logic [3:0]    mem_we;
   logic          ld_gnt, st_gnt, busy, timeout_err;

   vmem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .ld_req(ld_req), .ld_done(ld_done),
      .ld_addr0(ld_addr0), .ld_addr1(ld_addr1), .ld_addr2(ld_addr2), .ld_addr3(ld_addr3),
      .st_req(st_req), .st_done(st_done),
      .st_addr0(st_addr0), .st_addr1(st_addr1), .st_addr2(st_addr2), .st_addr3(st_addr3),
      .st_data0(st_data0), .st_data1(st_data1), .st_data2(st_data2), .st_data3(st_data3),
      .st_we(st_we),
      .mem_addr0(mem_addr0), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2), .mem_addr3(mem_addr3),
      .mem_wdata0(mem_wdata0), .mem_wdata1(mem_wdata1), .mem_wdata2(mem_wdata2), .mem_wdata3(mem_wdata3),
      .mem_we(mem_we),
      .ld_gnt(ld_gnt), .st_gnt(st_gnt), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Reference model: who owns the banks (0 none, 1 load, 2 store), plus the release gap.
   int   m_owner = 0;
   bit   m_gap = 1'b0;
   int   m_gap_owner = 0;
   int   m_last = 2;
   int   m_held = 0;
   bit   m_err = 1'b0;
   bit   m_valid = 1'b0;
   bit   fixed_store = 1'b0;
   out_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   function automatic out_t predict();
      out_t e;
      e        = '0;
      e.ld_gnt = (m_owner == 1);
      e.st_gnt = (m_owner == 2);
      e.busy   = (m_owner != 0) || m_gap;
      e.err    = m_err;
      if (m_owner == 1) begin
         e.addr = {ld_addr3, ld_addr2, ld_addr1, ld_addr0};
      end else if (m_owner == 2) begin
         e.addr  = {st_addr3, st_addr2, st_addr1, st_addr0};
         e.wdata = {st_data3, st_data2, st_data1, st_data0};
         e.we    = st_we;
      end
      return e;
   endfunction

   task automatic advance_model();
      bit my_req, my_done;
      if (rst) begin
         m_owner = 0; m_gap = 1'b0; m_last = 2; m_held = 0; m_err = 1'b0; m_valid = 1'b1;
      end else if (!m_valid) begin
         m_valid = 1'b0;
      end else if (m_gap) begin
         m_gap  = 1'b0;
         m_last = m_gap_owner;
      end else if (m_owner == 0) begin
         m_held = 0;
         if (ld_req && st_req) m_owner = (m_last == 2) ? 1 : 2;
         else if (ld_req)      m_owner = 1;
         else if (st_req)      m_owner = 2;
      end else begin
         my_req  = (m_owner == 1) ? ld_req  : st_req;
         my_done = (m_owner == 1) ? ld_done : st_done;
         if (my_done || !my_req || (WD_EN && m_held == TO - 1)) begin
            if (!my_done && my_req) m_err = 1'b1;
            m_gap_owner = m_owner;
            m_owner     = 0;
            m_gap       = 1'b1;
         end else begin
            m_held++;
         end
      end
   endtask

   task automatic step(input bit r, input bit lq, input bit ldn, input bit sq, input bit sdn);
      @(posedge clk);
      #1;
      rst = r; ld_req = lq; ld_done = ldn; st_req = sq; st_done = sdn;
      ld_addr0 = AW'($urandom); ld_addr1 = AW'($urandom);
      ld_addr2 = AW'($urandom); ld_addr3 = AW'($urandom);
      if (fixed_store) begin
         st_addr0 = AW'(0); st_addr1 = AW'(1); st_addr2 = AW'(2); st_addr3 = AW'(3);
         st_data0 = 32'h00000000; st_we = 4'hF;
      end else begin
         st_addr0 = AW'($urandom); st_addr1 = AW'($urandom);
         st_addr2 = AW'($urandom); st_addr3 = AW'($urandom);
         st_data0 = DW'($urandom); st_we = 4'($urandom);
      end
      st_data1 = DW'($urandom); st_data2 = DW'($urandom); st_data3 = DW'($urandom);
      if (m_valid) exp_q.push_back(predict());
      advance_model();
   endtask

   // Monitor: compares every predicted cycle away from the active edge.
   initial begin
      out_t e, a;
      forever begin
         @(negedge clk);
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {ld_gnt, st_gnt, busy, timeout_err, mem_we,
                 {mem_addr3, mem_addr2, mem_addr1, mem_addr0},
                 {mem_wdata3, mem_wdata2, mem_wdata1, mem_wdata0}};
            tests++;
            if (a !== e) begin
               fails++;
               $display("FAIL outputs cyc=%0d got ld_gnt=%0b st_gnt=%0b busy=%0b err=%0b we=%h addr=%h wdata=%h expected ld_gnt=%0b st_gnt=%0b busy=%0b err=%0b we=%h addr=%h wdata=%h",
                        cyc, a.ld_gnt, a.st_gnt, a.busy, a.err, a.we, a.addr, a.wdata,
                        e.ld_gnt, e.st_gnt, e.busy, e.err, e.we, e.addr, e.wdata);
            end
         end
      end
   end

   initial begin
      bit lq, sq;
      int waited;
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      // single store with fixed addresses/data
      fixed_store = 1'b1;
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
      fixed_store = 1'b0;
      // first tie right after reset
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0);
      step(0, 1, 1, 1, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0);
      // round-robin with both held, done after 4 grant cycles
      for (int i = 0; i < 40; i++)
         step(0, 1, (m_owner == 1) && (m_held == 3), 1, (m_owner == 2) && (m_held == 3));
      // non-owner done ignored, then reset mid-store-grant
      step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0);
      step(1, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
      // dropped store request
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
      // held store with no done: watchdog fires when enabled, error sticks until reset
      for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      // random traffic
      lq = 1'b0; sq = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(7, 0) == 0) lq = ~lq;
         if ($urandom_range(7, 0) == 0) sq = ~sq;
         step($urandom_range(149, 0) == 0, lq, $urandom_range(5, 0) == 0,
              sq, $urandom_range(5, 0) == 0);
      end
      step(0, 0, 0, 0, 0);
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(posedge clk);
         waited++;
      end
      if (exp_q.size() > 0) begin
         fails++;
         $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
